dac_write_scheduler: RTL and testbench

//  Sequences and arbitrates all writes to the I2C DAC controller (dac). Merges two requesters:
//  a periodic waveform engine (sawtooth/triangle/square/hold) paced by an internal tick divider,
//  and a host one-shot write port. Issues one wr_req pulse per transfer and waits for dac ready.

---
 rtl/dac_write_scheduler_if.sv | 21 ++
 rtl/dac_write_scheduler.sv | 159 +++++++++++++++
 tb/tb_dac_write_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_write_scheduler_if.sv
// Host write port and DAC write strobe bundle between the scheduler and its surroundings.
// The master side is the scheduler; the slave side is the host/DAC environment.
interface dac_write_scheduler_if;
    logic       host_req;
    logic [7:0] host_data;
    logic       host_ack;
    logic       host_drop;
    logic       dac_wr_req;
    logic [7:0] dac_wr_data;
    logic       dac_ready;

    modport master (
        input  host_req, host_data, dac_ready,
        output host_ack, host_drop, dac_wr_req, dac_wr_data
    );

    modport slave (
        output host_req, host_data, dac_ready,
        input  host_ack, host_drop, dac_wr_req, dac_wr_data
    );
endinterface

// File: rtl/dac_write_scheduler.sv
// Arbitrates host one-shot writes and a tick-paced waveform engine onto a single DAC write strobe,
// holding off each new strobe until the DAC has accepted and completed the previous transfer.
module dac_write_scheduler #(
    parameter int         TICK_DIV    = 1_000_000,
    parameter logic [7:0] WAVE_MIN    = 8'h70,
    parameter logic [7:0] WAVE_MAX    = 8'hFF,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    dac_write_scheduler_if.master         bus,
    input  logic                          wave_en_i,
    input  logic [1:0]                    wave_mode_i,
    output logic                          busy_o,
    output logic                          ack_err_o,
    output logic [7:0]                    overrun_cnt_o
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic                sel_host_q, sel_host_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                host_pend_q, host_pend_d;
    logic [DATA_W-1:0]   host_data_q, host_data_d;
    logic                wave_pend_q, wave_pend_d;
    logic [DATA_W-1:0]   wave_q, wave_d;
    logic                up_q, up_d;
    logic [7:0]          ovr_q, ovr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                tick, issue, iss_host, iss_wave, drop, ack_err;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Returns {direction_up, next_code}; triangle turns around so each endpoint is sent once.
    function automatic logic [DATA_W:0] wave_next(input logic [DATA_W-1:0] v, input logic up,
                                                  input logic [1:0] mode);
        logic [DATA_W:0] r;
        r = {up, v};
        case (mode)
            2'd1: r = {up, (v >= WAVE_MAX) ? WAVE_MIN : v + 8'd1};
            2'd2: begin
                if (up) r = (v >= WAVE_MAX) ? {1'b0, WAVE_MAX - 8'd1} : {1'b1, v + 8'd1};
                else    r = (v <= WAVE_MIN) ? {1'b1, WAVE_MIN + 8'd1} : {1'b0, v - 8'd1};
            end
            2'd3: r = {up, (v != WAVE_MIN) ? WAVE_MIN : WAVE_MAX};
            default: r = {up, v};
        endcase
        return r;
    endfunction

    assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign issue    = (state_q == ISSUE);
    assign iss_host = issue & sel_host_q;
    assign iss_wave = issue & ~sel_host_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        sel_host_d = sel_host_q;
        tmr_d      = tmr_q;
        ack_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dac_ready && (host_pend_q || wave_pend_q)) begin
                    state_d    = ISSUE;
                    sel_host_d = host_pend_q;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                tmr_d   = '0;
            end
            WAIT_ACK: begin
                if (!bus.dac_ready) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    ack_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WAIT_DONE: if (bus.dac_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A slot being issued this cycle counts as free for a new request or tick.
    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        host_pend_d = host_pend_q & ~iss_host;
        host_data_d = host_data_q;
        drop        = 1'b0;
        if (bus.host_req) begin
            if (host_pend_d) begin
                drop = 1'b1;
            end else begin
                host_pend_d = 1'b1;
                host_data_d = bus.host_data;
            end
        end
        wave_pend_d = wave_pend_q & ~iss_wave;
        ovr_d       = ovr_q;
        if (!wave_en_i) begin
            wave_pend_d = 1'b0;
        end else if (tick) begin
            if (wave_pend_d) ovr_d = sat_inc(ovr_q);
            wave_pend_d = 1'b1;
        end
        {up_d, wave_d} = iss_wave ? wave_next(wave_q, up_q, wave_mode_i) : {up_q, wave_q};
        data_d = data_q;
        if (state_q == IDLE && state_d == ISSUE) data_d = host_pend_q ? host_data_q : wave_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_host_q  <= 1'b0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            host_pend_q <= 1'b0;
            host_data_q <= '0;
            wave_pend_q <= 1'b0;
            wave_q      <= WAVE_MIN;
            up_q        <= 1'b1;
            ovr_q       <= '0;
            data_q      <= '0;
        end else begin
            sel_host_q  <= sel_host_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            host_pend_q <= host_pend_d;
            host_data_q <= host_data_d;
            wave_pend_q <= wave_pend_d;
            wave_q      <= wave_d;
            up_q        <= up_d;
            ovr_q       <= ovr_d;
            data_q      <= data_d;
        end
    end

    assign bus.dac_wr_req  = issue;
    assign bus.dac_wr_data = data_q;
    assign bus.host_ack    = iss_host;
    assign bus.host_drop   = drop;
    assign busy_o          = (state_q != IDLE);
    assign ack_err_o       = ack_err;
    assign overrun_cnt_o   = ovr_q;
endmodule

// File: tb/tb_dac_write_scheduler.sv
// Randomized bench for dac_write_scheduler: a timing-arithmetic reference model predicts every
// output each cycle, with a simple DAC that drops ready for a programmable number of cycles.
module tb_dac_write_scheduler;
    localparam int         TICK_DIV    = 10;
    localparam int         ACK_TIMEOUT = 4;
    localparam logic [7:0] WMIN        = 8'h70;
    localparam logic [7:0] WMAX        = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       wave_en;
    logic [1:0] wave_mode;
    logic       busy, ack_err;
    logic [7:0] overrun_cnt;

    dac_write_scheduler_if bus();

    dac_write_scheduler #(
        .TICK_DIV(TICK_DIV), .WAVE_MIN(WMIN), .WAVE_MAX(WMAX), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .wave_en_i(wave_en), .wave_mode_i(wave_mode),
        .busy_o(busy), .ack_err_o(ack_err), .overrun_cnt_o(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: cycle index since reset, when the scheduler is next free, pending work.
    int         c, free_at, err_at, dac_left, dac_len, issue_sel, next_sel, m_ovr;
    logic [7:0] next_data, last_data, m_hd, m_wave;
    logic       m_hp, m_wp, m_up;

    task automatic model_reset();
        c = 0; free_at = 0; err_at = -1; dac_left = 0; issue_sel = 0;
        next_data = 8'h00; last_data = 8'h00; m_hp = 1'b0; m_hd = 8'h00; m_wp = 1'b0;
        m_wave = WMIN; m_up = 1'b1; m_ovr = 0;
    endtask

    task automatic advance_wave(input logic [1:0] mode);
        int nv;
        case (mode)
            2'd1: begin
                nv = int'(m_wave) + 1;
                if (nv > int'(WMAX)) nv = int'(WMIN);
            end
            2'd2: begin
                nv = int'(m_wave) + (m_up ? 1 : -1);
                if (nv > int'(WMAX) || nv < int'(WMIN)) begin
                    m_up = !m_up;
                    nv = int'(m_wave) + (m_up ? 1 : -1);
                end
            end
            2'd3: nv = (m_wave == WMIN) ? int'(WMAX) : int'(WMIN);
            default: nv = int'(m_wave);
        endcase
        m_wave = nv[7:0];
    endtask

    // Called at a negedge: drive this cycle's inputs, check outputs, then advance the model.
    task automatic step(input int hpct, input bit rand_mode, input bit force_host,
                        input logic [7:0] fdata);
        logic ready, hreq, strobe, tick, keep, hold;
        hreq = force_host ? 1'b1 : ($urandom_range(99) < hpct);
        bus.host_req  = hreq;
        bus.host_data = force_host ? fdata : 8'($urandom);
        if (rand_mode && (c % TICK_DIV) == 0) begin
            wave_mode = 2'($urandom);
            wave_en   = ($urandom_range(3) != 0);
        end
        ready = (dac_left == 0);
        bus.dac_ready = ready;
        #1;
        strobe = (issue_sel != 0);
        if (strobe) begin
            free_at   = c + ((dac_len > 0) ? dac_len + 2 : ACK_TIMEOUT + 1);
            err_at    = (dac_len > 0) ? -1 : c + ACK_TIMEOUT;
            last_data = next_data;
        end
        check_eq("wr_req",    bus.dac_wr_req, strobe);
        check_eq("wr_data",   bus.dac_wr_data, last_data);
        check_eq("host_ack",  bus.host_ack, issue_sel == 1);
        check_eq("host_drop", bus.host_drop, hreq && m_hp && issue_sel != 1);
        check_eq("busy",      busy, c < free_at);
        check_eq("ack_err",   ack_err, c == err_at);
        check_eq("overrun",   overrun_cnt, m_ovr);

        tick     = ((c % TICK_DIV) == TICK_DIV - 1);
        next_sel = 0;
        if (!strobe && c >= free_at && ready && (m_hp || m_wp)) begin
            next_sel  = m_hp ? 1 : 2;
            next_data = m_hp ? m_hd : m_wave;
        end
        if (issue_sel == 2) advance_wave(wave_mode);
        hold = m_hp && issue_sel != 1;
        if (hreq && !hold) begin
            m_hp = 1'b1;
            m_hd = bus.host_data;
        end else begin
            m_hp = hold;
        end
        keep = m_wp && issue_sel != 2;
        if (!wave_en) begin
            m_wp = 1'b0;
        end else if (tick) begin
            if (keep && m_ovr < 255) m_ovr++;
            m_wp = 1'b1;
        end else begin
            m_wp = keep;
        end
        if (strobe) dac_left = dac_len;
        else if (dac_left > 0) dac_left--;
        issue_sel = next_sel;
        c++;
    endtask

    task automatic run_cycles(input int n, input int hpct, input bit rand_mode);
        for (int i = 0; i < n; i++) begin
            step(hpct, rand_mode, 1'b0, 8'h00);
            @(negedge clk);
        end
    endtask

    // Entered at a negedge; leaves at the following negedge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        bus.host_req = 1'b0;
        bus.dac_ready = 1'b1;
        #1;
        check_eq("rst_wr_req",  bus.dac_wr_req, 0);
        check_eq("rst_wr_data", bus.dac_wr_data, 0);
        check_eq("rst_ack",     bus.host_ack, 0);
        check_eq("rst_drop",    bus.host_drop, 0);
        check_eq("rst_busy",    busy, 0);
        check_eq("rst_ack_err", ack_err, 0);
        check_eq("rst_overrun", overrun_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit reached;
        rst = 1'b1; wave_en = 1'b0; wave_mode = 2'd0;
        bus.host_req = 1'b0; bus.host_data = 8'h00; bus.dac_ready = 1'b1;
        dac_len = 5;
        model_reset();
        @(negedge clk);

        // Sawtooth through a full wrap, then triangle, square and hold.
        do_reset();
        wave_en = 1'b1; wave_mode = 2'd1;
        run_cycles(1600, 0, 1'b0);
        do_reset();
        wave_mode = 2'd2;
        run_cycles(3000, 0, 1'b0);
        wave_mode = 2'd3;
        run_cycles(200, 0, 1'b0);
        wave_mode = 2'd0;
        run_cycles(100, 0, 1'b0);

        // Host write coinciding with a tick: host first, wave sample afterwards.
        dac_len = 20;
        do_reset();
        wave_mode = 2'd1;
        run_cycles(9, 0, 1'b0);
        step(0, 1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        run_cycles(60, 0, 1'b0);

        // Mixed random traffic with a slow DAC.
        run_cycles(1500, 15, 1'b1);

        // Very slow DAC: overrun counter must saturate.
        dac_len = 40;
        do_reset();
        wave_en = 1'b1; wave_mode = 2'd1;
        run_cycles(4500, 0, 1'b0);
        check_eq("ovr_sat", overrun_cnt, 255);

        // DAC never drops ready: ack timeout path.
        dac_len = 0;
        run_cycles(300, 10, 1'b1);

        // Reset while waiting for the DAC to finish.
        dac_len = 20;
        wave_en = 1'b1; wave_mode = 2'd1;
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step(0, 1'b0, 1'b0, 8'h00);
            reached = (c >= free_at - dac_len) && (c < free_at) && (issue_sel == 0) && (c > 2);
            @(negedge clk);
        end
        check_eq("mid_rst_reach", reached, 1);
        check_eq("mid_rst_busy", busy, 1);
        do_reset();
        run_cycles(100, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
